hazard_controller: RTL

Pipeline sequencing controller for the five-stage MIPS datapath. It generates the PC/IF_ID write-enables and the per-stage flush signals for three cases: load-use hazards, taken branches resolved in MEM, and jumps resolved in ID. It also tracks a multi-cycle Hi/Lo multiply unit (mult/madd/msub) and stalls any decode-stage Hi/Lo reader until the result commits. It sits beside the pipeline registers and is driven by decode-, execute- and memory-stage control signals.

---
 rtl/hazard_controller_pkg.sv | 22 ++
 rtl/hazard_controller_mul_busy_tracker.sv | 75 +++++++
 rtl/hazard_controller.sv | 113 +++++++++++
 3 files changed

// File: rtl/hazard_controller_pkg.sv
// Shared definitions for the hazard controller: instruction field positions,
// multiply tracker state encoding and legal multiply latency range.
package hazard_controller_pkg;

  // Register specifier fields of the decode-stage instruction
  localparam int unsigned RS_HI = 25;
  localparam int unsigned RS_LO = 21;
  localparam int unsigned RT_HI = 20;
  localparam int unsigned RT_LO = 16;
  localparam int unsigned REG_W = 5;

  // Hi/Lo multiply latency limits; the down-counter is sized for the maximum
  localparam int unsigned MUL_LATENCY_MIN = 2;
  localparam int unsigned MUL_LATENCY_MAX = 15;
  localparam int unsigned MUL_CNT_W       = 4;

  typedef enum logic {
    IDLE = 1'b0,
    BUSY = 1'b1
  } mul_state_e;

endpackage

// File: rtl/hazard_controller_mul_busy_tracker.sv
// Tracks one in-flight Hi/Lo multiply: busy window, commit pulse and
// cancellation when the multiply is flushed out of EX by a taken branch.
module mul_busy_tracker
  import hazard_controller_pkg::*;
#(
  parameter int unsigned MUL_LATENCY = 4
) (
  input  logic clk,
  input  logic rst,
  input  logic issue,     // multiply accepted out of decode this cycle
  input  logic flush_ex,  // taken branch flushes ID_EX/EX_MEM this cycle
  output logic busy,
  output logic done
);

  if ((MUL_LATENCY < MUL_LATENCY_MIN) || (MUL_LATENCY > MUL_LATENCY_MAX)) begin : g_bad_latency
    $error("mul_busy_tracker: MUL_LATENCY out of range");
  end

  localparam logic [MUL_CNT_W-1:0] CNT_LOAD = MUL_CNT_W'(MUL_LATENCY - 1);

  mul_state_e             state_q, state_d;
  logic [MUL_CNT_W-1:0]   cnt_q, cnt_d;
  logic                   age_q, age_d;

  // State register, countdown and first-cycle age flag
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      age_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      age_q   <= age_d;
    end
  end

  // Next state, countdown and busy/done generation
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    age_d   = 1'b0;
    busy    = 1'b0;
    done    = 1'b0;
    case (state_q)
      IDLE: begin
        if (issue) begin
          state_d = BUSY;
          cnt_d   = CNT_LOAD;
          age_d   = 1'b1;
        end
      end
      BUSY: begin
        busy = 1'b1;
        // Age flag set means the multiply is sitting in EX right now, so a
        // taken branch kills it before it can commit.
        if (flush_ex && age_q) begin
          state_d = IDLE;
          cnt_d   = '0;
        end else if (cnt_q == '0) begin
          done    = 1'b1;
          state_d = IDLE;
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end
      default: begin
        state_d = IDLE;
        cnt_d   = '0;
      end
    endcase
  end

endmodule

// File: rtl/hazard_controller.sv
// Pipeline sequencing controller: PC/IF_ID enables and per-stage flushes for
// branches, jumps, load-use and Hi/Lo multiply hazards, plus a stall counter.
module hazard_controller
  import hazard_controller_pkg::*;
#(
  parameter int unsigned MUL_LATENCY = 4,
  parameter int unsigned STALL_CNT_W = 16
) (
  input  logic                   Clk,
  input  logic                   Rst,
  input  logic [31:0]            Instruction_ID,
  input  logic                   MemRead_EX,
  input  logic [4:0]             WriteRegister_EX,
  input  logic                   Branch_IF,
  input  logic                   Jump_ID,
  input  logic                   MulStart_ID,
  input  logic                   HiLoRead_ID,
  output logic                   PCWrite,
  output logic                   IF_ID_Write,
  output logic                   IF_ID_Flush,
  output logic                   ID_EX_Flush,
  output logic                   EX_MEM_Flush,
  output logic                   MulBusy,
  output logic                   MulDone,
  output logic [STALL_CNT_W-1:0] StallCycles
);

  logic [REG_W-1:0] rs_id;
  logic [REG_W-1:0] rt_id;
  logic             unused_instr_bits;

  assign rs_id             = Instruction_ID[RS_HI:RS_LO];
  assign rt_id             = Instruction_ID[RT_HI:RT_LO];
  assign unused_instr_bits = ^{Instruction_ID[31:26], Instruction_ID[15:0]};

  logic load_use;
  logic hilo_stall;
  logic stall_req;
  logic mul_issue;
  logic mul_busy;
  logic mul_done;

  logic [STALL_CNT_W-1:0] stall_cnt_q, stall_cnt_d;

  mul_busy_tracker #(
    .MUL_LATENCY (MUL_LATENCY)
  ) u_mul_busy_tracker (
    .clk      (Clk),
    .rst      (Rst),
    .issue    (mul_issue),
    .flush_ex (Branch_IF),
    .busy     (mul_busy),
    .done     (mul_done)
  );

  assign MulBusy = mul_busy;
  assign MulDone = mul_done;

  // Hazard detection and multiply acceptance
  always_comb begin
    load_use   = MemRead_EX && (WriteRegister_EX != '0) &&
                 ((WriteRegister_EX == rs_id) || (WriteRegister_EX == rt_id));
    hilo_stall = mul_busy && (HiLoRead_ID || MulStart_ID);
    stall_req  = load_use || hilo_stall;
    mul_issue  = MulStart_ID && !Rst && !Branch_IF && !Jump_ID && !stall_req;
  end

  // Prioritised enables and flushes: reset, branch, jump, then stalls
  always_comb begin
    PCWrite      = 1'b1;
    IF_ID_Write  = 1'b1;
    IF_ID_Flush  = 1'b0;
    ID_EX_Flush  = 1'b0;
    EX_MEM_Flush = 1'b0;
    if (Rst) begin
      PCWrite      = 1'b0;
      IF_ID_Write  = 1'b0;
      IF_ID_Flush  = 1'b1;
      ID_EX_Flush  = 1'b1;
      EX_MEM_Flush = 1'b1;
    end else if (Branch_IF) begin
      IF_ID_Flush  = 1'b1;
      ID_EX_Flush  = 1'b1;
      EX_MEM_Flush = 1'b1;
    end else if (Jump_ID) begin
      IF_ID_Flush = 1'b1;
    end else if (stall_req) begin
      PCWrite     = 1'b0;
      IF_ID_Write = 1'b0;
      ID_EX_Flush = 1'b1;
    end
  end

  // Saturating stall-cycle count
  always_comb begin
    stall_cnt_d = stall_cnt_q;
    if (!PCWrite && (stall_cnt_q != '1)) begin
      stall_cnt_d = stall_cnt_q + 1'b1;
    end
  end

  // Stall counter register
  always_ff @(posedge Clk or posedge Rst) begin
    if (Rst) begin
      stall_cnt_q <= '0;
    end else begin
      stall_cnt_q <= stall_cnt_d;
    end
  end

  assign StallCycles = stall_cnt_q;

endmodule
